// File: rtl/morse_key_sequencer.sv
// Morse key sequencer: times key presses/releases in prescaled units and groups dot/dash elements into letters.
// States: IDLE no activity | MARK key down | SPACE key up inside a letter | EMIT letter offered | WGAP waiting for word gap
module morse_key_sequencer #(
  parameter logic [23:0] TICK_DIV         = 24'd2700000,
  parameter int unsigned DASH_UNITS       = 2,
  parameter int unsigned LETTER_GAP_UNITS = 2,
  parameter int unsigned WORD_GAP_UNITS   = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key,
  input  logic       out_ready,
  output logic       code_valid,
  output logic [5:0] code_bits,
  output logic [2:0] code_len,
  output logic       code_err,
  output logic       word_gap
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MARK  = 3'd1,
    SPACE = 3'd2,
    EMIT  = 3'd3,
    WGAP  = 3'd4
  } state_t;

  localparam logic [3:0]  DASH_U   = 4'(DASH_UNITS);
  localparam logic [3:0]  LETTER_U = 4'(LETTER_GAP_UNITS);
  localparam logic [3:0]  WORD_U   = 4'(WORD_GAP_UNITS);
  localparam logic [23:0] PRESC_TC = TICK_DIV - 24'd1;

  state_t      state, state_nxt;
  logic        key_q;
  logic        rise, fall, key_edge;
  logic [23:0] presc, presc_nxt;
  logic [3:0]  dur, dur_nxt;
  logic [5:0]  bits, bits_nxt;
  logic [2:0]  len, len_nxt;
  logic        err, err_nxt;
  logic        word_gap_nxt;
  logic        elem;
  logic        handshake;

  assign rise     = key & ~key_q;
  assign fall     = ~key & key_q;
  assign key_edge = rise | fall;

  always_comb begin
    presc_nxt = presc + 24'd1;
    dur_nxt   = dur;
    if (key_edge) begin
      presc_nxt = 24'd0;
      dur_nxt   = 4'd0;
    end else if (presc == PRESC_TC) begin
      presc_nxt = 24'd0;
      dur_nxt   = (dur == 4'd15) ? 4'd15 : dur + 4'd1;
    end
  end

  assign elem       = (dur >= DASH_U);
  assign code_valid = (state == EMIT);
  assign handshake  = code_valid & out_ready;

  // Gap thresholds compare the updated duration so the state moves on the edge that completes the unit.
  always_comb begin
    state_nxt    = state;
    bits_nxt     = bits;
    len_nxt      = len;
    err_nxt      = err;
    word_gap_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (rise) state_nxt = MARK;
      end
      MARK: begin
        if (fall) begin
          if (len < 3'd6) begin
            bits_nxt = bits | ({5'd0, elem} << len);
            len_nxt  = len + 3'd1;
          end else begin
            err_nxt = 1'b1;
          end
          state_nxt = SPACE;
        end
      end
      SPACE: begin
        if (rise)                       state_nxt = MARK;
        else if (dur_nxt >= LETTER_U)   state_nxt = EMIT;
      end
      EMIT: begin
        if (handshake) begin
          bits_nxt  = 6'd0;
          len_nxt   = 3'd0;
          err_nxt   = 1'b0;
          state_nxt = key ? MARK : WGAP;
        end
      end
      WGAP: begin
        if (rise) begin
          state_nxt = MARK;
        end else if (dur_nxt >= WORD_U) begin
          word_gap_nxt = 1'b1;
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      key_q    <= 1'b0;
      presc    <= 24'd0;
      dur      <= 4'd0;
      bits     <= 6'd0;
      len      <= 3'd0;
      err      <= 1'b0;
      word_gap <= 1'b0;
    end else begin
      state    <= state_nxt;
      key_q    <= key;
      presc    <= presc_nxt;
      dur      <= dur_nxt;
      bits     <= bits_nxt;
      len      <= len_nxt;
      err      <= err_nxt;
      word_gap <= word_gap_nxt;
    end
  end

  assign code_bits = bits;
  assign code_len  = len;
  assign code_err  = err;

endmodule

// File: tb/tb_morse_key_sequencer.sv
// Directed bench for morse_key_sequencer with TICK_DIV=4, DASH=2, LETTER_GAP=2, WORD_GAP=5.
module tb_morse_key_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key;
  logic       out_ready;
  logic       code_valid;
  logic [5:0] code_bits;
  logic [2:0] code_len;
  logic       code_err;
  logic       word_gap;

  int vectors     = 0;
  int miscompares = 0;
  int wg_seen     = 0;
  int hs_seen     = 0;
  int wg_base, hs_base;

  morse_key_sequencer #(
    .TICK_DIV        (24'd4),
    .DASH_UNITS      (2),
    .LETTER_GAP_UNITS(2),
    .WORD_GAP_UNITS  (5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key       (key),
    .out_ready (out_ready),
    .code_valid(code_valid),
    .code_bits (code_bits),
    .code_len  (code_len),
    .code_err  (code_err),
    .word_gap  (word_gap)
  );

  always #5 clk = ~clk;

  // Event counters sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (word_gap === 1'b1) wg_seen++;
    if (code_valid === 1'b1 && out_ready === 1'b1) hs_seen++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    assert (got === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_letter(input string tag, input logic [5:0] b, input logic [2:0] l, input logic e);
    check({tag, "_valid"}, 8'(code_valid), 8'd1);
    check({tag, "_bits"},  8'(code_bits),  8'(b));
    check({tag, "_len"},   8'(code_len),   8'(l));
    check({tag, "_err"},   8'(code_err),   8'(e));
  endtask

  initial begin
    rst_n     = 1'b1;
    key       = 1'b0;
    out_ready = 1'b1;
    #2 rst_n  = 1'b0;
    tick_n(2);
    check("rst_valid", 8'(code_valid), 8'd0);
    check("rst_bits",  8'(code_bits),  8'd0);
    check("rst_len",   8'(code_len),   8'd0);
    check("rst_err",   8'(code_err),   8'd0);
    check("rst_wgap",  8'(word_gap),   8'd0);
    rst_n = 1'b1;
    tick_n(3);

    // Letter A: dot then dash, out_ready high.
    wg_base = wg_seen; hs_base = hs_seen;
    key = 1'b1; tick_n(4);
    key = 1'b0; tick_n(4);
    key = 1'b1; tick_n(12);
    key = 1'b0; tick_n(8);
    check("a_valid_early", 8'(code_valid), 8'd0);
    tick_n(1);
    check_letter("a", 6'b000010, 3'd2, 1'b0);
    tick_n(1);
    check("a_valid_drop", 8'(code_valid), 8'd0);
    tick_n(10);
    check("a_wgap_early", 8'(word_gap), 8'd0);
    tick_n(1);
    check("a_wgap", 8'(word_gap), 8'd1);
    tick_n(1);
    check("a_wgap_end", 8'(word_gap), 8'd0);
    check("a_hs_count", 8'(hs_seen - hs_base), 8'd1);
    check("a_wg_count", 8'(wg_seen - wg_base), 8'd1);
    tick_n(3);

    // Backpressure on letter T.
    out_ready = 1'b0;
    key = 1'b1; tick_n(12);
    key = 1'b0; tick_n(9);
    check_letter("t_bp", 6'b000001, 3'd1, 1'b0);
    for (int i = 0; i < 50; i++) begin
      tick_n(1);
      check("t_bp_hold", {code_valid, code_err, code_len, code_bits[1:0], 1'b0},
            {1'b1, 1'b0, 3'd1, 2'b01, 1'b0});
    end
    wg_base = wg_seen;
    out_ready = 1'b1;
    tick_n(1);
    check("t_bp_drop", 8'(code_valid), 8'd0);
    tick_n(2);
    check("t_bp_wg_count", 8'(wg_seen - wg_base), 8'd1);
    tick_n(3);

    // Seven dots overflow the six-element letter.
    for (int i = 0; i < 7; i++) begin
      key = 1'b1; tick_n(4);
      key = 1'b0; tick_n(4);
    end
    tick_n(5);
    check_letter("ovf", 6'b000000, 3'd6, 1'b1);
    tick_n(14);

    // E then T within one word: no word_gap between them.
    wg_base = wg_seen; hs_base = hs_seen;
    key = 1'b1; tick_n(4);
    key = 1'b0; tick_n(9);
    check_letter("e", 6'b000000, 3'd1, 1'b0);
    tick_n(3);
    key = 1'b1; tick_n(12);
    key = 1'b0; tick_n(9);
    check_letter("t2", 6'b000001, 3'd1, 1'b0);
    tick_n(1);
    check("et_hs_count", 8'(hs_seen - hs_base), 8'd2);
    check("et_no_wgap", 8'(wg_seen - wg_base), 8'd0);
    tick_n(14);
    check("et_wg_after", 8'(wg_seen - wg_base), 8'd1);

    // Key pressed while a letter is held in EMIT.
    out_ready = 1'b0;
    key = 1'b1; tick_n(4);
    key = 1'b0; tick_n(9);
    check_letter("emit_e", 6'b000000, 3'd1, 1'b0);
    tick_n(2);
    key = 1'b1; tick_n(3);
    check("emit_hold", 8'(code_valid), 8'd1);
    out_ready = 1'b1;
    tick_n(1);
    check("emit_hs_drop", 8'(code_valid), 8'd0);
    check("emit_hs_len", 8'(code_len), 8'd0);
    tick_n(8);
    key = 1'b0; tick_n(9);
    check_letter("emit_next", 6'b000001, 3'd1, 1'b0);
    tick_n(14);

    // Reset in the middle of a letter, key still held on release.
    key = 1'b1; tick_n(12);
    key = 1'b0; tick_n(4);
    key = 1'b1; tick_n(6);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 8'(code_valid), 8'd0);
    check("mid_rst_bits",  8'(code_bits),  8'd0);
    check("mid_rst_len",   8'(code_len),   8'd0);
    check("mid_rst_err",   8'(code_err),   8'd0);
    check("mid_rst_wgap",  8'(word_gap),   8'd0);
    tick_n(2);
    rst_n = 1'b1;
    tick_n(4);
    key = 1'b0; tick_n(8);
    check("post_rst_early", 8'(code_valid), 8'd0);
    tick_n(1);
    check_letter("post_rst", 6'b000000, 3'd1, 1'b0);
    tick_n(14);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/morse_key_sequencer.md
# morse_key_sequencer

- Times the debounced Morse key level, classifies each press as dot or dash, and groups presses into letters using gap durations.
- Presents each completed letter on a valid/ready output to the decoder, and flags word boundaries.
- Sits between the key debouncer and the symbol-to-character decoder.
- All timing is in "units" derived from a clock prescaler.

## Interface
- TICK_DIV, 2700000: clk cycles per timing unit, 24-bit; must be ≥ 2.
- DASH_UNITS, 2: a press of ≥ this many units is a dash; otherwise it is a dot.
- LETTER_GAP_UNITS, 2: a release of ≥ this many units ends the letter.
- WORD_GAP_UNITS, 5: a release of ≥ this many units ends the word. Constraint: LETTER_GAP_UNITS < WORD_GAP_UNITS ≤ 15; all values ≥ 1.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- key  in  1  debounced key level, synchronous to clk, 1 = pressed.
- out_ready  in  1  decoder accepts the letter.
- code_valid  out  1  letter available.
- code_bits  out  6  element i at bit i; first element is bit 0; 0 = dot, 1 = dash; unused bits are 0.
- code_len  out  3  number of elements, 1..6.
- code_err  out  1  letter had more than 6 elements; extra elements were dropped.
- word_gap  out  1  one-cycle pulse at a word boundary.

## Operation
- **Edge detection**
  - key_q is a registered copy of key.
  - rise = key & ~key_q; fall = ~key & key_q.
  - Either edge is an "edge".
- **Prescaler and duration counter**
  - On an edge cycle: presc ← 0, dur ← 0.
  - Otherwise presc increments. When presc == TICK_DIV-1: presc ← 0 and dur ← dur+1, saturating at 15 (dur is 4-bit).
  - presc and dur run in every state.
- **States** (IDLE, MARK, SPACE, EMIT, WGAP):
  - IDLE: rise → MARK.
  - MARK: fall → classify dur (dur ≥ DASH_UNITS gives 1, else 0).
    - If len < 6: store the element at bit[len] and increment len.
    - Else: set err and discard the element.
    - Next state SPACE.
  - SPACE: rise → MARK. Else if dur ≥ LETTER_GAP_UNITS → EMIT. Rise has priority.
  - EMIT: code_valid = 1; code_bits/code_len/code_err hold the accumulated values, stable until handshake.
    - Handshake = code_valid & out_ready. On handshake, bits/len/err clear to 0.
    - Next state is MARK if key == 1 in that cycle; otherwise WGAP.
    - Edges during EMIT reset presc/dur only; the state is held.
  - WGAP: rise → MARK (no word_gap). Else if dur ≥ WORD_GAP_UNITS → word_gap pulse and IDLE.
    - If dur already qualifies on entry (slow out_ready), word_gap fires on the first WGAP cycle.
- code_valid is decoded from the state register (state == EMIT). word_gap is registered and high for exactly one cycle.
- A letter is never emitted with len = 0: EMIT is reachable only via MARK → SPACE.

## Timing
- Reset values:
  - state IDLE; key_q, presc, dur, bits, len, err all 0.
  - Outputs: code_valid 0, code_bits 0, code_len 0, code_err 0, word_gap 0.
- Key held high at rst_n deassertion is seen as a rise on the first clock: enter MARK.
- Reset mid-letter discards the letter; no code_valid is produced.
- dur reaches n (from 0) at the clock edge ending cycle t + n·TICK_DIV, where cycle t is the edge cycle.
- With fall at cycle r:
  - code_valid is first high in cycle r + LETTER_GAP_UNITS·TICK_DIV + 1.
  - With out_ready held at 1, code_valid is high for exactly 1 cycle.
  - word_gap is high in cycle r + WORD_GAP_UNITS·TICK_DIV + 1.
- Element classification has no output latency; it is visible only through code_* at EMIT.
- Outputs hold while out_ready = 0 (no drop, no change).

## Test plan
Parameters for all scenarios: TICK_DIV = 4, DASH_UNITS = 2, LETTER_GAP_UNITS = 2, WORD_GAP_UNITS = 5.

- **Letter "A", out_ready = 1:** press 4 cycles, release 4, press 12, release 40 → code_valid high 1 cycle, exactly 9 cycles after the final fall, with code_bits = 6'b000010, code_len = 2, code_err = 0. word_gap high 21 cycles after the final fall, then IDLE.
- **Backpressure:** letter "T" (press 12, release) with out_ready = 0 for 50 cycles → code_valid stays 1 and code_bits = 1, code_len = 1 are stable. Then raise out_ready → code_valid drops next cycle, word_gap pulses on the first WGAP cycle.
- **Overflow:** seven dots (press 4 / release 4 each), then release 40 → code_len = 6, code_bits = 0, code_err = 1. The next letter reports code_err = 0.
- **Intra-word letters:** "E", release 12 cycles, "T" → two separate code_valid handshakes and no word_gap between them.
- **Key pressed during EMIT:** out_ready = 0, press key, raise out_ready while key is high → handshake, state MARK, and the next element is classified from a duration measured from the press edge.
- **Reset mid-MARK:** assert rst_n low after 6 cycles of press → all outputs 0 immediately. Release rst_n with key high → MARK; release key after 4 cycles → a dot is recorded; no stale bits.
